// File: rtl/lsu_pkg.sv
// ============================================================================
//  lsu_pkg
//  Shared funct3 encodings, FSM state type and access-size helper.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   // 111 falls into the 8-byte bucket; it is rejected as illegal elsewhere.
   function automatic logic [3:0] f3_size(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: f3_size = 4'd1;
         F3_H, F3_HU: f3_size = 4'd2;
         F3_W, F3_WU: f3_size = 4'd4;
         default:     f3_size = 4'd8;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  lsu_align
//  Combinational byte-lane alignment: write enables, store replication,
//  load shift/extension and misaligned/illegal detection.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int NB = DATA_W / 8,
   localparam int LB = $clog2(NB)
) (
   input  logic [2:0]        funct3,
   input  logic              store,
   input  logic [LB-1:0]     lane,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [NB-1:0]     we,
   output logic [DATA_W-1:0] wdata_rep,
   output logic [DATA_W-1:0] rdata_ext,
   output logic              misaligned,
   output logic              illegal
);

   logic [3:0]        w_size;
   logic [DATA_W-1:0] w_shift;
   logic              w_sign;
   int                w_sz;
   int                w_ln;

   assign w_size  = f3_size(funct3);
   assign illegal = (funct3 == 3'b111) || (store && funct3[2]) ||
                    ((DATA_W == 32) && ((funct3 == F3_D) || (funct3 == F3_WU)));

   always_comb begin
      // Clamp keeps every lane index in range for sizes wider than the bus.
      w_sz       = (int'(w_size) > NB) ? NB : int'(w_size);
      w_ln       = int'(lane);
      misaligned = (w_ln & (w_sz - 1)) != 0;
      w_shift    = rdata >> (8 * w_ln);
      w_sign     = ~funct3[2] & w_shift[8*w_sz-1];
      for (int i = 0; i < NB; i++) begin
         we[i]               = (i >= w_ln) && (i < w_ln + w_sz);
         wdata_rep[8*i +: 8] = wdata[8*(i & (w_sz - 1)) +: 8];
         rdata_ext[8*i +: 8] = (i < w_sz) ? w_shift[8*i +: 8] : {8{w_sign}};
      end
   end

endmodule

`default_nettype wire

// File: rtl/lsu_core.sv
// ============================================================================
//  lsu_core
//  Load/store unit FSM: captures one request, runs it against a
//  valid/ready data memory and returns a one-cycle response pulse.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_core
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   localparam int NB = DATA_W / 8,
   localparam int LB = $clog2(NB)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [NB-1:0]     mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   lsu_state_e        r_state;
   lsu_state_e        w_next;
   logic              r_store;
   logic [2:0]        r_funct3;
   logic [LB-1:0]     r_lane;
   logic              r_err;
   logic [DATA_W-1:0] r_rdata;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [NB-1:0]     r_mem_we;
   logic [DATA_W-1:0] r_mem_wdata;

   logic              w_idle;
   logic [2:0]        w_funct3;
   logic              w_store;
   logic [LB-1:0]     w_lane;
   logic [NB-1:0]     w_we;
   logic [DATA_W-1:0] w_wdata_rep;
   logic [DATA_W-1:0] w_rdata_ext;
   logic              w_mis;
   logic              w_ill;
   logic              w_err;
   logic              w_accept;
   logic              w_capture;

   // The aligner sees the live request while idle and the captured one afterwards.
   assign w_idle    = (r_state == ST_IDLE);
   assign w_funct3  = w_idle ? req_funct3 : r_funct3;
   assign w_store   = w_idle ? req_store : r_store;
   assign w_lane    = w_idle ? req_addr[LB-1:0] : r_lane;
   assign w_err     = w_mis | w_ill;
   assign w_accept  = w_idle & req_valid;
   assign w_capture = ~r_store & mem_rvalid &
                      (((r_state == ST_REQ) & mem_ready) | (r_state == ST_WAIT));

   lsu_align #(
      .DATA_W(DATA_W)
   ) u_align (
      .funct3    (w_funct3),
      .store     (w_store),
      .lane      (w_lane),
      .wdata     (req_wdata),
      .rdata     (mem_rdata),
      .we        (w_we),
      .wdata_rep (w_wdata_rep),
      .rdata_ext (w_rdata_ext),
      .misaligned(w_mis),
      .illegal   (w_ill)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      mem_valid  = 1'b0;
      resp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_next = w_err ? ST_RESP : ST_REQ;
            end
         end
         ST_REQ: begin
            mem_valid = 1'b1;
            if (mem_ready) begin
               w_next = (r_store || mem_rvalid) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_store     <= 1'b0;
         r_funct3    <= 3'b000;
         r_lane      <= '0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_we    <= '0;
         r_mem_wdata <= '0;
      end else begin
         if (w_accept) begin
            r_store     <= req_store;
            r_funct3    <= req_funct3;
            r_lane      <= req_addr[LB-1:0];
            r_err       <= w_err;
            r_rdata     <= '0;
            r_mem_addr  <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
            r_mem_we    <= (req_store && !w_err) ? w_we : '0;
            r_mem_wdata <= req_store ? w_wdata_rep : '0;
         end
         if (w_capture) begin
            r_rdata <= w_rdata_ext;
         end
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;
   assign resp_err  = resp_valid & r_err;
   assign resp_data = resp_valid ? r_rdata : '0;

endmodule

`default_nettype wire

// File: doc/lsu_core.md
# lsu_core

Parametrised load/store unit that takes decoded RV32I/RV64I memory operations from the core and runs them against a variable-latency data memory through a valid/ready handshake. It handles byte-lane alignment, write-enable generation, sign/zero extension and misalignment detection. The core stalls on `req_ready`/`resp_valid` instead of assuming single-cycle memory. Data width scales to 64 bits, adding LD/SD/LWU.

## Interface
- `DATA_W`, 32: data path width, 32 or 64; `NB = DATA_W/8` byte lanes, `LB = log2(NB)`.
- `ADDR_W`, 32: byte-address width.

- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  core presents an operation.
- `req_ready`  out  1  LSU can accept; high only in IDLE.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 of the load/store.
- `req_addr`  in  ADDR_W  effective byte address.
- `req_wdata`  in  DATA_W  store data, LSB-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_data`  out  DATA_W  extended load result; 0 for stores and errors.
- `resp_err`  out  1  with `resp_valid`: misaligned or illegal funct3.
- `mem_valid`  out  1  memory request.
- `mem_ready`  in  1  memory accepts the request.
- `mem_addr`  out  ADDR_W  `req_addr` with low `LB` bits cleared.
- `mem_we`  out  NB  byte write enables; all 0 for loads.
- `mem_wdata`  out  DATA_W  lane-replicated store data.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  DATA_W  read data.

## Operation
- Size from `funct3`:
  - 000/100 → 1 B.
  - 001/101 → 2 B.
  - 010/110 → 4 B.
  - 011 → 8 B.
  - Bit 2 selects zero-extend.
- Illegal `funct3`, flagged with `resp_err`:
  - 111 always.
  - 011 and 110 when `DATA_W = 32`.
  - 1xx on stores.
- Misaligned: `addr % size != 0` gives an error. No memory access is issued.
- Lane: `lane = addr[LB-1:0]`.
- Stores:
  - `mem_we = ((1<<size)-1) << lane`.
  - `mem_wdata` = low `size` bytes of `req_wdata` replicated across `DATA_W`.
- Loads: `resp_data = ext(mem_rdata >> (8*lane))` truncated to `size` bytes. `ext` is sign- or zero-extension per `funct3[2]`.
- Request fields are registered at acceptance; later changes to the inputs are ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: `req_ready = 1`. On `req_valid`, capture the request. On error go to RESP; otherwise go to REQ.
  - REQ: `mem_valid = 1` with stable addr/we/wdata until `mem_ready`. Store goes to RESP; load goes to WAIT.
  - WAIT: capture and extend `mem_rdata` on `mem_rvalid`, then go to RESP. `mem_rvalid` may coincide with the `mem_ready` cycle; if so, go straight from REQ to RESP.
  - RESP: `resp_valid = 1` for exactly one cycle, then go to IDLE. There is no response backpressure.
- `mem_rvalid` outside REQ/WAIT is ignored.
- One outstanding operation at a time.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from `req_*` to `mem_*`.
- Acceptance cycle T is the cycle with `req_valid & req_ready`.
- Error response: `resp_valid` at T+1.
- Store with zero-wait memory: `mem_valid` at T+1, `mem_ready` at T+1, `resp_valid` at T+2.
- Load with zero-wait memory: `mem_rvalid` at T+1 or later. Minimum `resp_valid` at T+2; at T+3 if `rvalid` comes one cycle after `ready`.
- Back-to-back: the next request can be accepted in the cycle after `resp_valid`.
- Reset values: state IDLE, `req_ready = 1`, and 0 on all other outputs (`resp_*`, `mem_valid`, `mem_we`, `mem_addr`, `mem_wdata`).
- Reset mid-operation:
  - Aborts to IDLE on the next edge; `mem_valid` drops then.
  - No `resp_valid` is generated for the aborted operation.
  - Late `mem_rvalid` is discarded.

## Structure
- Package `lsu_pkg` holds:
  - funct3 constants (`F3_B` … `F3_WU`);
  - the FSM state enum;
  - a function returning the byte size for a `funct3`.
- Sub-module `lsu_align`, combinational and parametrised by `DATA_W`. Inputs: `funct3`, `lane`, store data, read data. Outputs: `we`, replicated wdata, extended rdata, misaligned/illegal flags.
- `lsu_core` holds the FSM and the capture registers.

## Test plan
- `DATA_W=32`, SB addr 0x103, wdata 0xAB, `mem_ready` at T+1 → `mem_addr` 0x100, `mem_we` 1000, `mem_wdata` 0xABABABAB, `resp_valid` at T+2, `resp_err` 0.
- `DATA_W=32`, LH addr 0x202, `mem_rdata` 0x8001_1234, `mem_ready` 2 cycles late → `resp_data` 0xFFFF_8001; LHU same request → 0x0000_8001.
- LW addr 0x0106 → `resp_err` 1 at T+1, `mem_valid` never asserted; 111 funct3 and SD at `DATA_W=32` → same.
- `DATA_W=64`, LWU addr 0x0C, `mem_rdata` 0xF000_0000_0000_0000 → `mem_addr` 0x08, `resp_data` 0x0000_0000_F000_0000; SD addr 0x10 → `mem_we` 0xFF.
- Reset asserted while in WAIT, `mem_rvalid` arrives 2 cycles later → no `resp_valid`; `req_ready` 1 the cycle after reset deasserts; the next LB completes correctly.
- Random `mem_ready`/`mem_rvalid` delays (0–5 cycles) with back-to-back requests → scoreboard against a byte-array memory model; `mem_*` stable while `mem_valid & !mem_ready`.
